// File: rtl/uart_mmio_pkg.sv
// rtl/uart_mmio_pkg.sv - shared types and lane helper for the UART MMIO sequencer
package uart_mmio_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef logic [1:0] lane_t;

    typedef enum logic [2:0] {
        IDLE,
        RX_WAIT,
        RX_POP,
        RX_GAP,
        TX_PUSH,
        DONE
    } state_t;

    // Byte lane of the current transfer: a word walks lanes 0..3 while cnt counts 3..0,
    // a single byte always uses lane 0.
    function automatic lane_t lane_of(input logic word, input lane_t cnt);
        lane_t last_lane;
        last_lane = lane_t'(BYTES_PER_WORD - 1);
        return word ? lane_t'(last_lane - cnt) : lane_t'(0);
    endfunction

endpackage

// File: rtl/uart_word_lane.sv
// rtl/uart_word_lane.sv - little-endian byte insert/extract and the load result register
module uart_word_lane
    import uart_mmio_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_wr,
    input  lane_t       i_lane,
    input  logic [7:0]  i_byte,
    input  logic [31:0] i_wdata,
    output logic [7:0]  o_byte,
    output logic [31:0] o_rdata
);

    logic [31:0] r_rdata;

    // Store path: pick the byte of the latched store word for the current lane
    assign o_byte  = i_wdata[{i_lane, 3'b000} +: 8];
    assign o_rdata = r_rdata;

    // Load path: clear on accept so unfilled lanes read as zero, then drop each popped byte into its lane
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= 32'h0;
        end else if (i_clr) begin
            r_rdata <= 32'h0;
        end else if (i_wr) begin
            r_rdata[{i_lane, 3'b000} +: 8] <= i_byte;
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// rtl/uart_mmio_ctrl.sv - CPU load/store to UART FIFO sequencer (optional RX timeout: UART_MMIO_RX_TIMEOUT_EN)
module uart_mmio_ctrl
    import uart_mmio_pkg::*;
#(
    parameter int unsigned          TO_W           = 24,
    parameter logic [TO_W-1:0]      TIMEOUT_CYCLES = 24'd1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic        word,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic        rx_rd_en,
    input  logic [7:0]  rx_rd_d,
    input  logic        rx_empty,
    output logic        tx_wr_en,
    output logic [7:0]  tx_wr_d,
    input  logic        tx_full
);

    state_t      r_state;
    lane_t       r_cnt;
    logic        r_word;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_rx_rd_en;

    lane_t       w_lane;
    logic        w_accept;
    logic        w_capture;
    logic        w_tx_wr_en;
    logic [7:0]  w_tx_byte;

    assign w_lane     = lane_of(r_word, r_cnt);
    assign w_accept   = (r_state == IDLE) && req;
    assign w_capture  = (r_state == RX_POP);
    // TX push is decided in the same cycle as the registered full flag so pushes can run back-to-back
    assign w_tx_wr_en = (r_state == TX_PUSH) && !tx_full;

    assign stall    = req && (r_state != DONE);
    assign done     = r_done;
    assign rx_rd_en = r_rx_rd_en;
    assign tx_wr_en = w_tx_wr_en;
    assign tx_wr_d  = w_tx_wr_en ? w_tx_byte : 8'h00;

    uart_word_lane u_lane (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_accept),
        .i_wr    (w_capture),
        .i_lane  (w_lane),
        .i_byte  (rx_rd_d),
        .i_wdata (r_wdata),
        .o_byte  (w_tx_byte),
        .o_rdata (rdata)
    );

`ifdef UART_MMIO_RX_TIMEOUT_EN
    logic [TO_W-1:0] r_to_cnt;
    logic            r_err;
    assign err = r_err;
`else
    logic w_unused_to;
    assign w_unused_to = ^TIMEOUT_CYCLES;
    assign err = 1'b0;
`endif

    // Request sequencer: one byte or four byte transfers, done pulse and pop strobe registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_word     <= 1'b0;
            r_wdata    <= 32'h0;
            r_done     <= 1'b0;
            r_rx_rd_en <= 1'b0;
`ifdef UART_MMIO_RX_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done     <= 1'b0;
            r_rx_rd_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_word  <= word;
                        r_wdata <= wdata;
                        r_cnt   <= word ? lane_t'(BYTES_PER_WORD - 1) : lane_t'(0);
                        r_state <= we ? TX_PUSH : RX_WAIT;
`ifdef UART_MMIO_RX_TIMEOUT_EN
                        r_to_cnt <= '0;
                        r_err    <= 1'b0;
`endif
                    end
                end
                RX_WAIT: begin
                    if (!rx_empty) begin
                        r_state    <= RX_POP;
                        r_rx_rd_en <= 1'b1;
                    end
`ifdef UART_MMIO_RX_TIMEOUT_EN
                    else if (r_to_cnt == TIMEOUT_CYCLES - TO_W'(1)) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_err   <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
`endif
                end
                RX_POP: begin
                    r_state <= RX_GAP;
                end
                RX_GAP: begin
                    if (r_cnt == '0) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_state <= RX_WAIT;
`ifdef UART_MMIO_RX_TIMEOUT_EN
                        r_to_cnt <= '0;
`endif
                    end
                end
                TX_PUSH: begin
                    if (!tx_full) begin
                        if (r_cnt == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb/tb_uart_mmio_ctrl.sv - self-checking bench for uart_mmio_ctrl
module tb_uart_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic        word;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;
    logic        rx_rd_en;
    logic [7:0]  rx_rd_d;
    logic        rx_empty;
    logic        tx_wr_en;
    logic [7:0]  tx_wr_d;
    logic        tx_full;

    int n_assert = 0;
    int n_fail   = 0;
    int first_push_k;
    int last_push_k;

    logic [7:0] rxq[$];
    logic [7:0] pending[$];

    always #5 clk = ~clk;

    uart_mmio_ctrl #(
        .TO_W           (24),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .we       (we),
        .word     (word),
        .wdata    (wdata),
        .rdata    (rdata),
        .stall    (stall),
        .done     (done),
        .err      (err),
        .rx_rd_en (rx_rd_en),
        .rx_rd_d  (rx_rd_d),
        .rx_empty (rx_empty),
        .tx_wr_en (tx_wr_en),
        .tx_wr_d  (tx_wr_d),
        .tx_full  (tx_full)
    );

    // RX FIFO model with registered empty flag and head byte
    always @(posedge clk) begin
        if (rx_rd_en === 1'b1 && rxq.size() > 0) void'(rxq.pop_front());
        rx_empty <= (rxq.size() == 0);
        rx_rd_d  <= (rxq.size() > 0) ? rxq[0] : 8'h00;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one request from a negedge and follow it to done, checking protocol and results
    task automatic run_op(input string tag, input logic t_we, input logic t_word,
                          input logic [31:0] t_wdata, input int feed_gap,
                          input int full_after, input int full_len, input bit rand_full,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_n);
        int k;
        int pushes;
        int pops;
        int full_cnt;
        int last_pop;
        bit seen_done;
        bit viol_rx;
        bit viol_tx;
        bit viol_stall;
        bit viol_gap;
        logic [31:0] tx_acc;
        logic [31:0] got_rdata;
        logic        got_err;
        k = 0; pushes = 0; pops = 0; full_cnt = 0; last_pop = 0;
        seen_done = 0; viol_rx = 0; viol_tx = 0; viol_stall = 0; viol_gap = 0;
        tx_acc = 32'h0; got_rdata = 32'h0; got_err = 1'b0;
        first_push_k = -1; last_push_k = -1;
        req = 1'b1; we = t_we; word = t_word; wdata = t_wdata;
        while (k < 2000) begin
            if (pending.size() > 0 && feed_gap > 0 && (k % feed_gap) == 0)
                rxq.push_back(pending.pop_front());
            if (rand_full) tx_full = ($urandom_range(0, 3) == 0);
            else if (full_after >= 0 && pushes >= full_after && full_cnt < full_len) begin
                tx_full = 1'b1;
                full_cnt++;
            end else tx_full = 1'b0;
            #1;
            if (tx_wr_en === 1'b1) begin
                if (tx_full !== 1'b0) viol_tx = 1;
                if (pushes < 4) tx_acc[8*pushes +: 8] = tx_wr_d;
                if (first_push_k < 0) first_push_k = k;
                last_push_k = k;
                pushes++;
            end
            if (rx_rd_en === 1'b1) begin
                if (rx_empty !== 1'b0) viol_rx = 1;
                if (pops > 0 && (k - last_pop) < 3) viol_gap = 1;
                last_pop = k;
                pops++;
            end
            if (done === 1'b1) begin
                seen_done = 1;
                if (stall !== 1'b0) viol_stall = 1;
                got_rdata = rdata;
                got_err   = err;
                req = 1'b0;
                break;
            end else if (stall !== 1'b1) viol_stall = 1;
            @(negedge clk);
            k++;
        end
        req = 1'b0;
        tx_full = 1'b0;
        chk({tag, ".done_seen"}, 32'(seen_done), 32'd1);
        if (t_we) begin
            chk({tag, ".push_count"}, pushes, exp_n);
            chk({tag, ".tx_bytes"}, tx_acc, t_word ? t_wdata : {24'h0, t_wdata[7:0]});
        end else begin
            chk({tag, ".pop_count"}, pops, exp_n);
            chk({tag, ".rdata"}, got_rdata, exp_rdata);
        end
        chk({tag, ".err"}, 32'(got_err), 32'(exp_err));
        chk({tag, ".pop_while_empty"}, 32'(viol_rx), 32'd0);
        chk({tag, ".push_while_full"}, 32'(viol_tx), 32'd0);
        chk({tag, ".stall_shape"}, 32'(viol_stall), 32'd0);
        chk({tag, ".pop_gap"}, 32'(viol_gap), 32'd0);
        if (exp_lat >= 0) chk({tag, ".latency"}, k, exp_lat);
        @(negedge clk);
        #1;
        chk({tag, ".done_one_cycle"}, 32'(done), 32'd0);
        chk({tag, ".rdata_held"}, rdata, got_rdata);
    endtask

    initial begin
        logic [7:0]  b [4];
        logic [31:0] exp_rd;
        logic        r_we;
        logic        r_word;
        logic [31:0] r_wd;
        int          pops;

        rst = 1'b1; req = 1'b0; we = 1'b0; word = 1'b0; wdata = 32'h0; tx_full = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset.rdata", rdata, 32'h0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.err", 32'(err), 32'd0);
        chk("reset.rx_rd_en", 32'(rx_rd_en), 32'd0);
        chk("reset.tx_wr_en", 32'(tx_wr_en), 32'd0);
        chk("reset.tx_wr_d", 32'(tx_wr_d), 32'd0);
        chk("reset.stall_req0", 32'(stall), 32'd0);
        req = 1'b1;
        #1;
        chk("reset.stall_req1", 32'(stall), 32'd1);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Byte load of a preloaded byte
        rxq.push_back(8'hA5);
        @(negedge clk);
        run_op("byte_load", 0, 0, 32'h0, 0, -1, 0, 0, 32'h0000_00A5, 0, 4, 1);

        // Word load of four preloaded bytes, little-endian
        rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33); rxq.push_back(8'h44);
        @(negedge clk);
        run_op("word_load", 0, 1, 32'h0, 0, -1, 0, 0, 32'h4433_2211, 0, 13, 4);

        // Word store with free TX: four back-to-back pushes, LSB first
        run_op("word_store", 1, 1, 32'hDEAD_BEEF, 0, -1, 0, 0, 32'h0, 0, 5, 4);
        chk("word_store.first_push_cycle", first_push_k, 1);
        chk("word_store.push_span", last_push_k - first_push_k, 3);

        // Byte store
        run_op("byte_store", 1, 0, 32'h1234_5678, 0, -1, 0, 0, 32'h0, 0, 2, 1);

        // Word load with one byte arriving every 10 cycles
        pending.push_back(8'h0A); pending.push_back(8'hB1); pending.push_back(8'hC2); pending.push_back(8'hD3);
        run_op("slow_rx", 0, 1, 32'h0, 10, -1, 0, 0, 32'hD3C2_B10A, 0, -1, 4);

        // Word store, TX full for 7 cycles after the 2nd push
        run_op("tx_backpressure", 1, 1, 32'hCAFE_F00D, 0, 2, 7, 0, 32'h0, 0, 12, 4);

        // Async reset after 2 of 4 pops; the next byte loads see the remaining bytes
        rxq.push_back(8'hC1); rxq.push_back(8'hC2); rxq.push_back(8'hC3); rxq.push_back(8'hC4);
        @(negedge clk);
        req = 1'b1; we = 1'b0; word = 1'b1; pops = 0;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (rx_rd_en === 1'b1) pops++;
            if (pops == 2) break;
            @(negedge clk);
        end
        chk("rst_mid.pops_before", pops, 2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid.rdata", rdata, 32'h0);
        chk("rst_mid.done", 32'(done), 32'd0);
        chk("rst_mid.rx_rd_en", 32'(rx_rd_en), 32'd0);
        chk("rst_mid.tx_wr_en", 32'(tx_wr_en), 32'd0);
        chk("rst_mid.tx_wr_d", 32'(tx_wr_d), 32'd0);
        chk("rst_mid.stall_eq_req", 32'(stall), 32'd1);
        req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst_1", 0, 0, 32'h0, 0, -1, 0, 0, 32'h0000_00C3, 0, 4, 1);
        run_op("after_rst_2", 0, 0, 32'h0, 0, -1, 0, 0, 32'h0000_00C4, 0, 4, 1);

`ifdef UART_MMIO_RX_TIMEOUT_EN
        // Empty RX byte load times out after 16 wait cycles
        run_op("timeout_byte", 0, 0, 32'h0, 0, -1, 0, 0, 32'h0, 1, 17, 0);
        // Word load with a single byte: partial result kept, rest zero
        pending.push_back(8'h9C);
        run_op("timeout_word", 0, 1, 32'h0, 1, -1, 0, 0, 32'h0000_009C, 1, 20, 1);
        // A following normal request clears err
        rxq.push_back(8'h5E);
        @(negedge clk);
        run_op("err_cleared", 0, 0, 32'h0, 0, -1, 0, 0, 32'h0000_005E, 0, 4, 1);
`endif

        // Randomised requests against a byte-level reference model
        for (int n = 0; n < 24; n++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_word = 1'($urandom_range(0, 1));
            r_wd   = $urandom;
            if (r_we) begin
                run_op($sformatf("rand%0d_st", n), 1, r_word, r_wd, 0, -1, 0, 1'($urandom_range(0, 1)),
                       32'h0, 0, -1, r_word ? 4 : 1);
            end else begin
                for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
                exp_rd = r_word ? {b[3], b[2], b[1], b[0]} : {24'h0, b[0]};
                if ($urandom_range(0, 1) == 1) begin
                    for (int i = 0; i < (r_word ? 4 : 1); i++) rxq.push_back(b[i]);
                    @(negedge clk);
                    run_op($sformatf("rand%0d_ld", n), 0, r_word, 32'h0, 0, -1, 0, 0,
                           exp_rd, 0, -1, r_word ? 4 : 1);
                end else begin
                    for (int i = 0; i < (r_word ? 4 : 1); i++) pending.push_back(b[i]);
                    run_op($sformatf("rand%0d_ld", n), 0, r_word, 32'h0, $urandom_range(1, 4), -1, 0, 0,
                           exp_rd, 0, -1, r_word ? 4 : 1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
